// File: rtl/serial_cmp_ctrl_if.sv
// Handshake/operand bundle for serial_cmp_ctrl: master drives start and operands,
// slave returns busy/done and the registered eq/gt/lt result.
interface serial_cmp_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output start, a, b,
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, a, b,
        output busy, done, eq, gt, lt
    );
endinterface

// File: rtl/serial_cmp_ctrl.sv
// Serial unsigned magnitude compare: one 2-bit slice stepped MSB digit first, N = WIDTH/2 RUN cycles then a one-cycle DONE.
// Optional SERIAL_CMP_EARLY_EXIT_EN ends RUN at the first differing digit. Start is accepted only in IDLE.
module serial_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_cmp_ctrl_if.slave  bus
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] D_LAST = CW'(N - 1);

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("serial_cmp_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_d;
    logic             r_e;
    logic             r_g;
    logic             r_busy;
    logic             r_done;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;

    logic [1:0]       w_da;
    logic [1:0]       w_db;
    logic             w_e_next;
    logic             w_g_next;
    logic             w_last;

    assign w_da = r_a[2*r_d +: 2];
    assign w_db = r_b[2*r_d +: 2];

    // Once e drops the decision is final; lower digits cannot change it.
    always_comb begin
        w_e_next = r_e;
        w_g_next = r_g;
        if (r_e) begin
            if (w_da > w_db) begin
                w_e_next = 1'b0;
                w_g_next = 1'b1;
            end else if (w_da < w_db) begin
                w_e_next = 1'b0;
                w_g_next = 1'b0;
            end
        end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        w_last = (r_d == '0) || !w_e_next;
`else
        w_last = (r_d == '0);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_e     <= 1'b1;
            r_g     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_d     <= D_LAST;
                        r_e     <= 1'b1;
                        r_g     <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_e <= w_e_next;
                    r_g <= w_g_next;
                    if (w_last) begin
                        r_eq    <= w_e_next;
                        r_gt    <= !w_e_next && w_g_next;
                        r_lt    <= !w_e_next && !w_g_next;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_d <= r_d - 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.eq   = r_eq;
    assign bus.gt   = r_gt;
    assign bus.lt   = r_lt;
endmodule
